pwm_audio_capture: RTL

Receive-side counterpart to the APU's 1-bit PWM audio output. It locks onto the PWM frame and measures the high time of each frame to recover the 8-bit sample value. Recovered samples are buffered in a small first-word-fall-through FIFO behind a valid/ready handshake. It sits between the `uio_out[7]` sound pin (looped back, or driven by a bench/second board) and any consumer such as a logic-analyser tap or a loopback checker.

---
 rtl/pwm_audio_capture.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_audio_capture.sv
// pwm_audio_capture: recovers 8-bit samples from a 1-bit PWM audio stream.
// The block locks onto the first rising edge of the sampled input and counts
// high cycles over each PERIOD-clock frame. Each count, saturated to 255, is
// pushed into a small first-word-fall-through FIFO read over valid/ready.
// Optional build macro: PWM_CAPTURE_SYNC_EN. When it is defined, a 2-flop
// synchroniser sits in front of the input register, for a pwm driven from
// another board or clock domain. When it is undefined, pwm is registered once,
// for same-clock loopback.
module pwm_audio_capture #(
   parameter int PERIOD     = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pwm,
   input  logic                          sample_ready,
   output logic [7:0]                    sample_data,
   output logic                          sample_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          locked,
   output logic                          overflow
);

   localparam int FRAME_W = $clog2(PERIOD);
   localparam int HIGH_W  = $clog2(PERIOD + 1);
   localparam int SAT_W   = (HIGH_W > 8) ? HIGH_W : 8;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;

   typedef enum logic {S_IDLE, S_MEASURE} state_t;

   // ---------------- input sampling ----------------
   logic pwm_s_q;
   logic pwm_prev_q;

`ifdef PWM_CAPTURE_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   // Two-flop synchroniser, then the input register that forms pwm_s.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         pwm_s_q <= 1'b0;
      end else begin
         sync1_q <= pwm;
         sync2_q <= sync1_q;
         pwm_s_q <= sync2_q;
      end
   end
`else
   // Same-clock input: one register stage forms pwm_s.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_s_q <= 1'b0;
      end else begin
         pwm_s_q <= pwm;
      end
   end
`endif

   // Previous pwm_s value, used to detect the rising edge that starts a lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_prev_q <= 1'b0;
      end else begin
         pwm_prev_q <= pwm_s_q;
      end
   end

   // ---------------- frame measurement FSM ----------------
   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;   // index of the current frame cycle
   logic [HIGH_W-1:0]   high_cnt_q, high_cnt_d;     // high cycles seen before the current cycle
   logic                locked_q, locked_d;
   logic [HIGH_W-1:0]   high_total;                 // high cycles including the current cycle
   logic [SAT_W-1:0]    total_ext;
   logic                push;
   logic [7:0]          push_data;

   // Next-state logic: lock on a rising edge, then count a frame and emit its sample.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      high_cnt_d  = high_cnt_q;
      push        = 1'b0;
      high_total  = high_cnt_q + HIGH_W'(pwm_s_q);
      total_ext   = SAT_W'(high_total);
      push_data   = (total_ext > SAT_W'(255)) ? 8'hFF : total_ext[7:0];
      unique case (state_q)
         S_IDLE: begin
            frame_cnt_d = '0;
            high_cnt_d  = '0;
            if (pwm_s_q && !pwm_prev_q) begin
               // This cycle is frame cycle 0 and it is high.
               state_d     = S_MEASURE;
               frame_cnt_d = FRAME_W'(1);
               high_cnt_d  = HIGH_W'(1);
            end
         end
         S_MEASURE: begin
            if (frame_cnt_q == FRAME_W'(PERIOD - 1)) begin
               push        = 1'b1;
               frame_cnt_d = '0;
               high_cnt_d  = '0;
               if (high_total == '0) begin
                  // A silent frame means the stream went away: lock is dropped.
                  state_d = S_IDLE;
               end
            end else begin
               frame_cnt_d = frame_cnt_q + FRAME_W'(1);
               high_cnt_d  = high_total;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      locked_d = (state_d == S_MEASURE);
   end

   // FSM state, frame counters and the registered lock flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= '0;
         high_cnt_q  <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         high_cnt_q  <= high_cnt_d;
         locked_q    <= locked_d;
      end
   end

   // ---------------- sample FIFO ----------------
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              full;
   logic              pop;
   logic              wr_en;

   // Push/pop arbitration. A push into a full FIFO succeeds only if a pop frees a slot.
   always_comb begin
      full       = (level_q == LVL_W'(FIFO_DEPTH));
      pop        = (level_q != '0) && sample_ready;
      wr_en      = push && (!full || pop);
      overflow_d = overflow_q | (push && full && !pop);
      wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d   = pop   ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      unique case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // Sample storage. Its contents need no reset because the read port is gated by occupancy.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign sample_valid = (level_q != '0);
   assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : 8'd0;
   assign fifo_level   = level_q;
   assign locked       = locked_q;
   assign overflow     = overflow_q;

endmodule
